// File: rtl/vitenc_conv_pkg.sv
// Shared definitions for the convolutional encoder: reference generator
// polynomials and the frame-termination FSM state encoding.
package vitenc_conv_pkg;

    // K=3 (7,5) rate-1/2 code: out_data[1] taps 111, out_data[0] taps 101.
    localparam logic [5:0]  K3_G75     = 6'b111101;

    // K=7 (171,133) rate-1/2 code: out_data[1] taps 1111001, out_data[0] taps 1011011.
    localparam logic [13:0] K7_G171133 = 14'b1111001_1011011;

    // RUN encodes information bits; TAIL flushes K-1 zeros after in_last.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TAIL = 1'b1
    } vitenc_state_e;

endpackage : vitenc_conv_pkg

// File: rtl/vitenc_parity.sv
// Generator AND/XOR-reduce for a rate-1/N code. u_i[K-1] is the current
// input bit, u_i[K-2] the most recent past bit, u_i[0] the oldest one.
// Purely combinational so the decoder's branch-metric model can reuse it.
module vitenc_parity
    import vitenc_conv_pkg::*;
#(
    parameter int                K = 3,
    parameter int                N = 2,
    parameter logic [N*K-1:0]    G = (N*K)'(K3_G75)
) (
    input  logic [K-1:0] u_i,
    output logic [N-1:0] p_o
);

    // One parity bit per generator: XOR of the tapped register/input bits.
    always_comb begin
        // NOTE: defaulting every combinational output first keeps the loop from inferring a latch.
        p_o = '0;
        for (int n = 0; n < N; n++) begin
            p_o[n] = ^(G[n*K +: K] & u_i);
        end
    end

endmodule : vitenc_parity

// File: rtl/vitenc_conv.sv
// Rate-1/N, constraint-length-K feed-forward convolutional encoder with
// valid/ready on both sides, a single registered output word, and optional
// zero-tail termination that returns the shift register to zero per frame.
module vitenc_conv
    import vitenc_conv_pkg::*;
#(
    parameter int                K    = 3,
    parameter int                N    = 2,
    parameter logic [N*K-1:0]    G    = (N*K)'(K3_G75),
    parameter int                TERM = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last
);

    localparam int TW = $clog2(K);

    // Reject parameter sets the shift register and output port cannot represent.
    if (K < 2 || K > 9) begin : g_bad_k
        $error("vitenc_conv: K must be in 2..9");
    end
    if (N < 2 || N > 4) begin : g_bad_n
        $error("vitenc_conv: N must be in 2..4");
    end

    vitenc_state_e   state_q, state_d;
    logic [K-2:0]    sreg_q, sreg_d;
    logic [TW-1:0]   tail_cnt_q, tail_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    out_data_q, out_data_d;
    logic            out_last_q, out_last_d;

    logic            slot_free;
    logic            fire;
    logic            d_bit;
    logic [K-1:0]    u;
    logic [N-1:0]    parity;
    logic [K-2:0]    sreg_shift;

    // The output slot can take a new word if empty or being drained this cycle.
    assign slot_free = !out_valid_q || out_ready;

    // Input is taken only in RUN, never while reset is asserted.
    assign in_ready  = !rst && (state_q == ST_RUN) && slot_free;

    // Tail steps inject zeros; RUN steps inject the information bit.
    assign d_bit     = (state_q == ST_RUN) ? in_data : 1'b0;
    assign u         = {d_bit, sreg_q};

    // A step either consumes an accepted input or emits one tail word.
    assign fire      = (state_q == ST_RUN)
                       ? (in_valid && in_ready)
                       : slot_free;

    vitenc_parity #(
        .K (K),
        .N (N),
        .G (G)
    ) u_parity (
        .u_i (u),
        .p_o (parity)
    );

    // Next-state: encode step, frame/tail sequencing and output-slot bookkeeping.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        tail_cnt_d  = tail_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        // Newest bit enters at the top, oldest bit falls off the bottom.
        sreg_shift        = sreg_q >> 1;
        sreg_shift[K-2]   = d_bit;

        if (fire) begin
            out_data_d  = parity;
            out_valid_d = 1'b1;
            sreg_d      = sreg_shift;
            out_last_d  = 1'b0;
            unique case (state_q)
                ST_RUN: begin
                    if (in_last) begin
                        if (TERM != 0) begin
                            state_d    = ST_TAIL;
                            tail_cnt_d = TW'(K - 2);
                        end else begin
                            // Continuous mode: frame boundary is marked but memory carries on.
                            out_last_d = 1'b1;
                        end
                    end
                end
                ST_TAIL: begin
                    if (tail_cnt_q == '0) begin
                        // K-1 zeros have now been shifted in, so sreg is back to zero.
                        out_last_d = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        tail_cnt_d = tail_cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset; reset drops any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            sreg_q      <= '0;
            tail_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            tail_cnt_q  <= tail_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule : vitenc_conv
